// File: rtl/cache_mem_arbiter_if.sv
// One cache-side 4-word burst port: request/address/write data in, read data/offset/ready back.
interface cache_mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 16
);
    logic              mem_req;
    logic              mem_wren;
    logic [ADDR_W-1:0] mem_address;
    logic [DATA_W-1:0] to_mem;
    logic [DATA_W-1:0] from_mem;
    logic [1:0]        mem_offset;
    logic              mem_ready;

    modport master (
        output mem_req, mem_wren, mem_address, to_mem,
        input  from_mem, mem_offset, mem_ready
    );

    modport slave (
        input  mem_req, mem_wren, mem_address, to_mem,
        output from_mem, mem_offset, mem_ready
    );
endinterface

// File: rtl/cache_mem_arbiter.sv
// Two-cache (A = icache, B = dcache) arbiter onto a single burst-of-4 SDRAM command/data port.
// Optional MEMARB_ROUND_ROBIN_EN replaces fixed B-over-A priority with alternating tie-break.
module cache_mem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    cache_mem_arbiter_if.slave a_port,
    cache_mem_arbiter_if.slave b_port,
    output logic              sd_cmd_valid,
    input  logic              sd_cmd_ready,
    output logic              sd_cmd_wren,
    output logic [ADDR_W-1:0] sd_cmd_addr,
    input  logic              sd_wr_next,
    output logic [DATA_W-1:0] sd_wdata,
    input  logic              sd_rd_valid,
    input  logic [DATA_W-1:0] sd_rd_data,
    output logic              err
);
    typedef enum logic [2:0] {
        S_IDLE, S_WDRAIN, S_WCAPT, S_WCMD, S_WDATA, S_RCMD, S_RDATA
    } state_t;

    state_t state_q, state_d;
    logic [1:0]        cnt_q, cnt_d;
    logic              gnt_q;
    logic [ADDR_W-1:0] gaddr_q;
    logic              rrdy_q, rlast_q, err_q;
    logic [1:0]        roff_q;
    logic [DATA_W-1:0] rdata_q;

    logic [1:0]        req_w, wren_in_w, pend_w, srv_w, wren_w;
    logic [ADDR_W-1:0] addr_in_w [2];
    logic [ADDR_W-1:0] addr_w    [2];
    logic [DATA_W-1:0] to_mem_w  [2];
    logic [DATA_W-1:0] wbuf_w    [4];
    logic              grant_w, gsel_w, done_w, rbeat_w, drain_w, cap_en_w, proto_err_w;
    logic [1:0]        glow_w, cap_idx_w;

    assign req_w        = {b_port.mem_req, a_port.mem_req};
    assign wren_in_w    = {b_port.mem_wren, a_port.mem_wren};
    assign addr_in_w[0] = a_port.mem_address;
    assign addr_in_w[1] = b_port.mem_address;
    assign to_mem_w[0]  = a_port.to_mem;
    assign to_mem_w[1]  = b_port.to_mem;

    assign glow_w  = gaddr_q[1:0];
    assign drain_w = (state_q == S_WDRAIN);
    assign rbeat_w = (state_q == S_RDATA) && sd_rd_valid;
    // Last mem_ready-high cycle of the served port; it may take a new request one cycle later.
    assign done_w  = (drain_w && cnt_q == 2'd3) || rlast_q;
    assign grant_w = (state_q == S_IDLE) && (pend_w != 2'b00);

`ifdef MEMARB_ROUND_ROBIN_EN
    logic last_q;
    always_ff @(posedge clk) begin
        if (rst)          last_q <= 1'b0;
        else if (grant_w) last_q <= gsel_w;
    end
    assign gsel_w = (pend_w == 2'b11) ? ~last_q : pend_w[1];
`else
    assign gsel_w = pend_w[1];
`endif

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_port
            logic              pend_q, srv_q, wren_q;
            logic [ADDR_W-1:0] addr_q;
            always_ff @(posedge clk) begin
                if (rst) begin
                    pend_q <= 1'b0;
                    srv_q  <= 1'b0;
                    wren_q <= 1'b0;
                    addr_q <= '0;
                end else begin
                    if (!pend_q && !srv_q && req_w[gi]) begin
                        pend_q <= 1'b1;
                        wren_q <= wren_in_w[gi];
                        addr_q <= addr_in_w[gi];
                    end
                    if (grant_w && gsel_w == 1'(gi)) begin
                        pend_q <= 1'b0;
                        srv_q  <= 1'b1;
                    end
                    if (srv_q && gnt_q == 1'(gi) && done_w) srv_q <= 1'b0;
                end
            end
            assign pend_w[gi] = pend_q;
            assign srv_w[gi]  = srv_q;
            assign wren_w[gi] = wren_q;
            assign addr_w[gi] = addr_q;
        end
    endgenerate

    // Cache write data lags its offset by one cycle, so word k lands while offset k+1 is shown.
    assign cap_en_w  = (drain_w && cnt_q != 2'd0) || (state_q == S_WCAPT);
    assign cap_idx_w = glow_w ^ ((state_q == S_WCAPT) ? 2'd3 : cnt_q - 2'd1);

    generate
        for (gi = 0; gi < 4; gi++) begin : g_wbuf
            logic [DATA_W-1:0] word_q;
            always_ff @(posedge clk) begin
                if (cap_en_w && cap_idx_w == 2'(gi)) word_q <= to_mem_w[gnt_q];
            end
            assign wbuf_w[gi] = word_q;
        end
    endgenerate

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            S_IDLE: begin
                cnt_d = 2'd0;
                if (grant_w) state_d = wren_w[gsel_w] ? S_WDRAIN : S_RCMD;
            end
            S_WDRAIN: begin
                cnt_d = cnt_q + 2'd1;
                if (cnt_q == 2'd3) state_d = S_WCAPT;
            end
            S_WCAPT: begin
                cnt_d   = 2'd0;
                state_d = S_WCMD;
            end
            S_WCMD:  if (sd_cmd_ready) state_d = S_WDATA;
            S_WDATA: if (sd_wr_next) begin
                cnt_d = cnt_q + 2'd1;
                if (cnt_q == 2'd3) state_d = S_IDLE;
            end
            S_RCMD:  if (sd_cmd_ready) state_d = S_RDATA;
            S_RDATA: if (sd_rd_valid) begin
                cnt_d = cnt_q + 2'd1;
                if (cnt_q == 2'd3) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign proto_err_w = ((state_q == S_RDATA) && !sd_rd_valid && cnt_q != 2'd0)
                       || (sd_rd_valid && state_q != S_RDATA)
                       || (sd_wr_next && state_q != S_WDATA);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 2'd0;
            gnt_q   <= 1'b0;
            gaddr_q <= '0;
            rrdy_q  <= 1'b0;
            rlast_q <= 1'b0;
            roff_q  <= 2'd0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (grant_w) begin
                gnt_q   <= gsel_w;
                gaddr_q <= addr_w[gsel_w];
            end
            rrdy_q  <= rbeat_w;
            rlast_q <= rbeat_w && cnt_q == 2'd3;
            rdata_q <= rbeat_w ? sd_rd_data : '0;
            // Beats arrive in wrap order from the critical word; map back to the cache's XOR offset.
            roff_q  <= rbeat_w ? (glow_w ^ (glow_w + cnt_q)) : 2'd0;
            if (proto_err_w) err_q <= 1'b1;
        end
    end

    assign sd_cmd_valid = (state_q == S_WCMD) || (state_q == S_RCMD);
    assign sd_cmd_wren  = (state_q == S_WCMD);
    assign sd_cmd_addr  = (state_q == S_WCMD) ? {gaddr_q[ADDR_W-1:2], 2'b00} :
                          (state_q == S_RCMD) ? gaddr_q : '0;
    assign sd_wdata     = (state_q == S_WDATA) ? wbuf_w[cnt_q] : '0;
    assign err          = err_q;

    assign a_port.mem_ready  = !gnt_q && (drain_w || rrdy_q);
    assign a_port.mem_offset = gnt_q ? 2'd0 : (drain_w ? cnt_q : roff_q);
    assign a_port.from_mem   = gnt_q ? '0 : rdata_q;
    assign b_port.mem_ready  = gnt_q && (drain_w || rrdy_q);
    assign b_port.mem_offset = !gnt_q ? 2'd0 : (drain_w ? cnt_q : roff_q);
    assign b_port.from_mem   = !gnt_q ? '0 : rdata_q;
endmodule
